// File: rtl/dpbram3_port_arbiter_pkg.sv
// Shared definitions for the BRAM port-A arbiter:
// requester indices and fill engine state encoding.
package dpbram3_port_arbiter_pkg;

  localparam int SRC_CPU  = 0;
  localparam int SRC_GPU  = 1;
  localparam int SRC_FILL = 2;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/dpbram3_port_arbiter_rr_arb3.sv
// 3-way round-robin arbiter. Ports: clk, rst (sync, high),
// req[2:0] in, grant[2:0] one-hot out (combinational).
module rr_arb3
  import dpbram3_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] grant
);

  logic [1:0] ptr;
  logic [1:0] p1;
  logic [1:0] p2;
  logic [1:0] win;

  function automatic logic [1:0] inc3(
    input logic [1:0] v
  );
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign p1 = inc3(ptr);
  assign p2 = inc3(p1);

  always_comb begin
    grant = '0;
    win   = ptr;
    if (req[ptr]) begin
      grant[ptr] = 1'b1;
      win        = ptr;
    end else if (req[p1]) begin
      grant[p1] = 1'b1;
      win       = p1;
    end else if (req[p2]) begin
      grant[p2] = 1'b1;
      win       = p2;
    end
  end

  // Pointer only moves past a winner; idle cycles keep it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 2'd0;
    end else if (|grant) begin
      ptr <= inc3(win);
    end
  end

endmodule

// File: rtl/dpbram3_port_arbiter.sv
// Shares BRAM port A between CPU, GPU and a fill engine.
// Ports: cpu_*/gpu_* req/resp, fill_* control, ram_* port A.
module dpbram3_port_arbiter
  import dpbram3_port_arbiter_pkg::*;
#(
  parameter int DP  = 512,
  parameter int DW  = 8,
  parameter int N   = 3,
  parameter int AW  = $clog2(DP) - 1,
  parameter int BDW = N * DW - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_valid,
  output logic         cpu_ready,
  input  logic         cpu_we,
  input  logic [AW:0]  cpu_addr,
  input  logic [BDW:0] cpu_wdata,
  output logic         cpu_rvalid,
  output logic [BDW:0] cpu_rdata,
  input  logic         gpu_valid,
  output logic         gpu_ready,
  input  logic         gpu_we,
  input  logic [AW:0]  gpu_addr,
  input  logic [BDW:0] gpu_wdata,
  output logic         gpu_rvalid,
  output logic [BDW:0] gpu_rdata,
  input  logic         fill_start,
  input  logic [AW:0]  fill_base,
  input  logic [AW+1:0] fill_len,
  input  logic [BDW:0] fill_value,
  output logic         fill_busy,
  output logic         fill_done,
  output logic         ram_ce,
  output logic         ram_wr,
  output logic [AW:0]  ram_addr,
  output logic [BDW:0] ram_din,
  input  logic [BDW:0] ram_dout
);

  localparam logic [AW:0] ADDR_LAST = (AW+1)'(DP - 1);
  localparam logic [AW+1:0] REM_ONE = (AW+2)'(1);

  fill_state_t state_q;
  fill_state_t state_d;
  logic [AW:0]   cur_addr;
  logic [AW+1:0] remaining;
  logic [BDW:0]  value_q;
  logic          load;
  logic          step;

  logic [2:0] req;
  logic [2:0] grant;
  logic       cpu_rd_q;
  logic       gpu_rd_q;

  // Nothing may touch the RAM while reset is held.
  assign req = rst ? 3'b000
                   : {state_q == FS_RUN, gpu_valid, cpu_valid};

  rr_arb3 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant)
  );

  assign cpu_ready = grant[SRC_CPU];
  assign gpu_ready = grant[SRC_GPU];

  always_comb begin
    ram_ce   = 1'b0;
    ram_wr   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    unique case (1'b1)
      grant[SRC_CPU]: begin
        ram_ce   = 1'b1;
        ram_wr   = cpu_we;
        ram_addr = cpu_addr;
        ram_din  = cpu_wdata;
      end
      grant[SRC_GPU]: begin
        ram_ce   = 1'b1;
        ram_wr   = gpu_we;
        ram_addr = gpu_addr;
        ram_din  = gpu_wdata;
      end
      grant[SRC_FILL]: begin
        ram_ce   = 1'b1;
        ram_wr   = 1'b1;
        ram_addr = cur_addr;
        ram_din  = value_q;
      end
      default: ;
    endcase
  end

  // Tag tells which requester owns next cycle's douta.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rd_q <= 1'b0;
      gpu_rd_q <= 1'b0;
    end else begin
      cpu_rd_q <= grant[SRC_CPU] & ~cpu_we;
      gpu_rd_q <= grant[SRC_GPU] & ~gpu_we;
    end
  end

  assign cpu_rvalid = cpu_rd_q & ~rst;
  assign gpu_rvalid = gpu_rd_q & ~rst;
  assign cpu_rdata  = cpu_rvalid ? ram_dout : '0;
  assign gpu_rdata  = gpu_rvalid ? ram_dout : '0;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      FS_IDLE: begin
        if (fill_start) begin
          load    = 1'b1;
          state_d = (fill_len == '0) ? FS_DONE : FS_RUN;
        end
      end
      FS_RUN: begin
        if (grant[SRC_FILL]) begin
          step = 1'b1;
          if (remaining == REM_ONE) begin
            state_d = FS_DONE;
          end
        end
      end
      FS_DONE: state_d = FS_IDLE;
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FS_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      value_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cur_addr  <= fill_base;
        remaining <= fill_len;
        value_q   <= fill_value;
      end else if (step) begin
        cur_addr  <= (cur_addr == ADDR_LAST)
                     ? '0 : cur_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  assign fill_busy = (state_q != FS_IDLE) & ~rst;
  assign fill_done = (state_q == FS_DONE) & ~rst;

endmodule

// File: tb/tb_dpbram3_port_arbiter.sv
// Bench for dpbram3_port_arbiter with a port-A BRAM model
// and a queue-based reference model of the arbiter rules.
module tb_dpbram3_port_arbiter;

  localparam int DP  = 512;
  localparam int AW  = 8;
  localparam int BDW = 23;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_valid, cpu_ready, cpu_we;
  logic [AW:0]   cpu_addr;
  logic [BDW:0]  cpu_wdata, cpu_rdata;
  logic          cpu_rvalid;
  logic          gpu_valid, gpu_ready, gpu_we;
  logic [AW:0]   gpu_addr;
  logic [BDW:0]  gpu_wdata, gpu_rdata;
  logic          gpu_rvalid;
  logic          fill_start, fill_busy, fill_done;
  logic [AW:0]   fill_base;
  logic [AW+1:0] fill_len;
  logic [BDW:0]  fill_value;
  logic          ram_ce, ram_wr;
  logic [AW:0]   ram_addr;
  logic [BDW:0]  ram_din, ram_dout;

  always #5 clk = ~clk;

  dpbram3_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .gpu_valid  (gpu_valid),
    .gpu_ready  (gpu_ready),
    .gpu_we     (gpu_we),
    .gpu_addr   (gpu_addr),
    .gpu_wdata  (gpu_wdata),
    .gpu_rvalid (gpu_rvalid),
    .gpu_rdata  (gpu_rdata),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .ram_ce     (ram_ce),
    .ram_wr     (ram_wr),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  // DPBRAM3 port A stand-in: registered read, port B idle.
  logic [BDW:0] bram [DP];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wr) bram[ram_addr] <= ram_din;
      else        ram_dout <= bram[ram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: pending fill addresses as a queue.
  int           m_ptr;
  int           fq[$];
  logic [BDW:0] m_val;
  bit           m_done;
  bit           m_crv, m_grv;
  logic [BDW:0] m_crd, m_grd;
  logic [BDW:0] m_mem [DP];
  int           m_win;

  task automatic check_model();
    bit rq[3];
    bit e_ce, e_wr, e_crv, e_grv, e_busy;
    logic [AW:0] e_a;
    logic [BDW:0] e_d;
    @(negedge clk);
    rq[0] = cpu_valid && !rst;
    rq[1] = gpu_valid && !rst;
    rq[2] = (fq.size() > 0) && !rst;
    m_win = -1;
    for (int k = 0; k < 3; k++) begin
      int s;
      s = (m_ptr + k) % 3;
      if (m_win < 0 && rq[s]) m_win = s;
    end
    e_ce = 1'b0; e_wr = 1'b0; e_a = '0; e_d = '0;
    if (m_win == 0) begin
      e_ce = 1'b1; e_wr = cpu_we; e_a = cpu_addr; e_d = cpu_wdata;
    end else if (m_win == 1) begin
      e_ce = 1'b1; e_wr = gpu_we; e_a = gpu_addr; e_d = gpu_wdata;
    end else if (m_win == 2) begin
      e_ce = 1'b1; e_wr = 1'b1; e_a = 9'(fq[0]); e_d = m_val;
    end
    chk("cpu_ready", 32'(cpu_ready), 32'(m_win == 0));
    chk("gpu_ready", 32'(gpu_ready), 32'(m_win == 1));
    chk("ram_ce", 32'(ram_ce), 32'(e_ce));
    chk("ram_wr", 32'(ram_wr), 32'(e_wr));
    chk("ram_addr", 32'(ram_addr), 32'(e_a));
    chk("ram_din", 32'(ram_din), 32'(e_d));
    e_crv = m_crv && !rst;
    e_grv = m_grv && !rst;
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
    chk("gpu_rvalid", 32'(gpu_rvalid), 32'(e_grv));
    if (e_crv) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_crd));
    if (e_grv) chk("gpu_rdata", 32'(gpu_rdata), 32'(m_grd));
    e_busy = !rst && (fq.size() > 0 || m_done);
    chk("fill_busy", 32'(fill_busy), 32'(e_busy));
    chk("fill_done", 32'(fill_done), 32'(!rst && m_done));
  endtask

  task automatic update_model();
    bit nd, was_busy;
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; fq.delete(); m_done = 0;
      m_crv = 0; m_grv = 0;
    end else begin
      nd = 0;
      was_busy = (fq.size() > 0) || m_done;
      m_crv = (m_win == 0) && !cpu_we;
      m_grv = (m_win == 1) && !gpu_we;
      m_crd = m_mem[cpu_addr];
      m_grd = m_mem[gpu_addr];
      if (m_win == 0 && cpu_we) m_mem[cpu_addr] = cpu_wdata;
      if (m_win == 1 && gpu_we) m_mem[gpu_addr] = gpu_wdata;
      if (m_win == 2) begin
        int a;
        a = fq.pop_front();
        m_mem[a] = m_val;
        if (fq.size() == 0) nd = 1;
      end
      if (fill_start && !was_busy) begin
        m_val = fill_value;
        if (fill_len == '0) nd = 1;
        for (int i = 0; i < int'(fill_len); i++)
          fq.push_back((int'(fill_base) + i) % DP);
      end
      m_done = nd;
      if (m_win >= 0) m_ptr = (m_win + 1) % 3;
    end
    #1;
  endtask

  task automatic step();
    check_model();
    update_model();
  endtask

  typedef struct {
    bit           r;
    bit           cv;
    bit           cwe;
    logic [AW:0]  ca;
    logic [BDW:0] cwd;
    bit           gv;
    logic [AW:0]  ga;
    bit           ecr;
    bit           egr;
    bit           ecrv;
    bit           egrv;
    logic [BDW:0] ecrd;
    logic [BDW:0] egrd;
  } vec_t;

  vec_t tv[9];

  initial begin
    int busy_n, done_at, wcount, n_ok, last_f, bad_gap, nf;
    logic [AW:0] addrs[$];
    logic [AW:0] exp3[4];

    tv[0] = '{1'b0, 1'b1, 1'b1, 9'h010, 24'h123456, 1'b0, 9'h000,
              1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0};
    tv[1] = '{1'b0, 1'b1, 1'b0, 9'h010, 24'h0, 1'b0, 9'h000,
              1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0};
    tv[2] = '{1'b0, 1'b0, 1'b0, 9'h000, 24'h0, 1'b0, 9'h000,
              1'b0, 1'b0, 1'b1, 1'b0, 24'h123456, 24'h0};
    tv[3] = '{1'b1, 1'b1, 1'b0, 9'h010, 24'h0, 1'b1, 9'h010,
              1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0};
    tv[4] = '{1'b0, 1'b1, 1'b0, 9'h010, 24'h0, 1'b1, 9'h010,
              1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0};
    tv[5] = '{1'b0, 1'b1, 1'b0, 9'h010, 24'h0, 1'b1, 9'h010,
              1'b0, 1'b1, 1'b1, 1'b0, 24'h123456, 24'h0};
    tv[6] = '{1'b0, 1'b1, 1'b0, 9'h010, 24'h0, 1'b1, 9'h010,
              1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 24'h123456};
    tv[7] = '{1'b0, 1'b1, 1'b0, 9'h010, 24'h0, 1'b1, 9'h010,
              1'b0, 1'b1, 1'b1, 1'b0, 24'h123456, 24'h0};
    tv[8] = '{1'b0, 1'b0, 1'b0, 9'h000, 24'h0, 1'b0, 9'h000,
              1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 24'h123456};
    exp3[0] = 9'h1FE; exp3[1] = 9'h1FF;
    exp3[2] = 9'h000; exp3[3] = 9'h001;

    for (int i = 0; i < DP; i++) m_mem[i] = '0;
    m_ptr = 0; m_done = 0; m_crv = 0; m_grv = 0;
    m_val = '0; m_crd = '0; m_grd = '0; m_win = -1;

    rst = 1'b1;
    cpu_valid = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    gpu_valid = 0; gpu_we = 0; gpu_addr = '0; gpu_wdata = '0;
    fill_start = 0; fill_base = '0; fill_len = '0;
    fill_value = '0;
    repeat (2) step();
    rst = 1'b0;

    // Directed table: CPU write/read, reset, CPU+GPU alternation.
    for (int i = 0; i < 9; i++) begin
      rst = tv[i].r;
      cpu_valid = tv[i].cv; cpu_we = tv[i].cwe;
      cpu_addr = tv[i].ca; cpu_wdata = tv[i].cwd;
      gpu_valid = tv[i].gv; gpu_we = 1'b0;
      gpu_addr = tv[i].ga; gpu_wdata = '0;
      check_model();
      chk("tv_cpu_ready", 32'(cpu_ready), 32'(tv[i].ecr));
      chk("tv_gpu_ready", 32'(gpu_ready), 32'(tv[i].egr));
      chk("tv_cpu_rvalid", 32'(cpu_rvalid), 32'(tv[i].ecrv));
      chk("tv_gpu_rvalid", 32'(gpu_rvalid), 32'(tv[i].egrv));
      if (tv[i].ecrv)
        chk("tv_cpu_rdata", 32'(cpu_rdata), 32'(tv[i].ecrd));
      if (tv[i].egrv)
        chk("tv_gpu_rdata", 32'(gpu_rdata), 32'(tv[i].egrd));
      update_model();
    end
    rst = 1'b0; cpu_valid = 0; gpu_valid = 0;

    // Full-depth clear: len = DP.
    fill_start = 1; fill_base = '0; fill_len = 10'd512;
    fill_value = '0;
    step();
    fill_start = 0;
    done_at = -1;
    for (int c = 0; c < 600 && done_at < 0; c++) begin
      check_model();
      if (fill_done) done_at = c;
      update_model();
    end
    chk("clear_done_at", 32'(done_at), 32'd512);
    step();

    // Wrapping fill, no other traffic.
    fill_start = 1; fill_base = 9'h1FE; fill_len = 10'd4;
    fill_value = 24'hABCDEF;
    step();
    fill_start = 0;
    busy_n = 0; done_at = -1; addrs.delete();
    for (int c = 0; c < 8; c++) begin
      check_model();
      if (ram_ce && ram_wr) addrs.push_back(ram_addr);
      if (fill_busy) busy_n++;
      if (fill_done && done_at < 0) done_at = c;
      update_model();
    end
    chk("fill3_writes", 32'(addrs.size()), 32'd4);
    for (int i = 0; i < addrs.size() && i < 4; i++)
      chk("fill3_addr", 32'(addrs[i]), 32'(exp3[i]));
    chk("fill3_busy_cycles", 32'(busy_n), 32'd5);
    chk("fill3_done_at", 32'(done_at), 32'd4);

    // Zero-length fill.
    fill_start = 1; fill_base = 9'h055; fill_len = '0;
    fill_value = 24'hFFFFFF;
    step();
    fill_start = 0;
    busy_n = 0; done_at = -1; wcount = 0;
    for (int c = 0; c < 4; c++) begin
      check_model();
      if (ram_ce) wcount++;
      if (fill_busy) busy_n++;
      if (fill_done && done_at < 0) done_at = c;
      update_model();
    end
    chk("fill5_writes", 32'(wcount), 32'd0);
    chk("fill5_busy_cycles", 32'(busy_n), 32'd1);
    chk("fill5_done_at", 32'(done_at), 32'd0);

    // Reset in the middle of a fill.
    fill_start = 1; fill_base = 9'h080; fill_len = 10'd8;
    fill_value = 24'h111111;
    step();
    fill_start = 0;
    wcount = 0;
    for (int c = 0; c < 10 && wcount < 3; c++) begin
      check_model();
      if (ram_ce && ram_wr) wcount++;
      update_model();
    end
    chk("fill6_pre_writes", 32'(wcount), 32'd3);
    rst = 1;
    check_model();
    chk("fill6_rst_busy", 32'(fill_busy), 32'd0);
    chk("fill6_rst_ce", 32'(ram_ce), 32'd0);
    update_model();
    rst = 0;
    fill_start = 1; fill_base = 9'h0C0; fill_len = 10'd2;
    fill_value = 24'h222222;
    check_model();
    chk("fill6_idle_busy", 32'(fill_busy), 32'd0);
    chk("fill6_idle_ce", 32'(ram_ce), 32'd0);
    update_model();
    fill_start = 0;
    check_model();
    chk("fill6_restart_busy", 32'(fill_busy), 32'd1);
    chk("fill6_restart_addr", 32'(ram_addr), 32'h0C0);
    update_model();
    repeat (3) step();
    cpu_valid = 1; cpu_we = 0; cpu_addr = 9'h082;
    step();
    cpu_addr = 9'h083;
    check_model();
    chk("fill6_rd_written", 32'(cpu_rdata), 32'h111111);
    update_model();
    cpu_valid = 0;
    check_model();
    chk("fill6_rd_untouched", 32'(cpu_rdata), 32'h0);
    update_model();

    // Fill under full CPU+GPU read load.
    cpu_valid = 1; cpu_we = 0; cpu_addr = 9'h100;
    gpu_valid = 1; gpu_we = 0; gpu_addr = 9'h101;
    fill_start = 1; fill_base = 9'h040; fill_len = 10'd16;
    fill_value = 24'h5A5A5A;
    step();
    fill_start = 0;
    done_at = -1; last_f = -1; bad_gap = 0; nf = 0;
    for (int c = 0; c < 60 && done_at < 0; c++) begin
      check_model();
      if (ram_ce && ram_wr) begin
        if (last_f >= 0 && c - last_f != 3) bad_gap++;
        last_f = c; nf++;
      end
      if (fill_done) done_at = c;
      update_model();
    end
    chk("fill4_writes", 32'(nf), 32'd16);
    chk("fill4_bad_gaps", 32'(bad_gap), 32'd0);
    chk("fill4_done_window",
        32'(done_at >= 46 && done_at <= 48), 32'd1);
    gpu_valid = 0;
    n_ok = 0;
    for (int i = 0; i <= 16; i++) begin
      cpu_valid = (i < 16);
      cpu_addr = 9'(9'h040 + i);
      check_model();
      if (cpu_rvalid && cpu_rdata === 24'h5A5A5A) n_ok++;
      update_model();
    end
    chk("fill4_readback", 32'(n_ok), 32'd16);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      cpu_valid = ($urandom_range(0, 3) != 0);
      cpu_we = $urandom_range(0, 1) == 1;
      cpu_addr = 9'($urandom_range(0, 63));
      cpu_wdata = 24'($urandom);
      gpu_valid = ($urandom_range(0, 3) != 0);
      gpu_we = $urandom_range(0, 1) == 1;
      gpu_addr = 9'($urandom_range(0, 63));
      gpu_wdata = 24'($urandom);
      fill_start = ($urandom_range(0, 15) == 0);
      fill_base = 9'($urandom_range(0, 511));
      fill_len = ($urandom_range(0, 5) == 0)
                 ? '0 : 10'($urandom_range(1, 40));
      fill_value = 24'($urandom);
      step();
    end
    rst = 0; cpu_valid = 0; gpu_valid = 0; fill_start = 0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
